// File: rtl/mem_stage_sized.sv
// mem_stage_sized: MIPS MEM stage with sized loads/stores, MEM/WB latch, debug step gate and debug read port.
// Define MEM_MISALIGN_EXC_EN to suppress misaligned accesses and flag them on o_misalign.
module mem_stage_sized #(
    parameter int NB_BITS  = 32,
    parameter int NB_DEPTH = 10,
    parameter int NB_REG   = 5,
    parameter int NB_WB    = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [NB_BITS-1:0]  i_addr,
    input  logic [NB_BITS-1:0]  i_data,
    input  logic                i_mem_wr,
    input  logic                i_mem_rd,
    input  logic [1:0]          i_size,
    input  logic                i_unsigned,
    input  logic [NB_REG-1:0]   i_reg_dst,
    input  logic [NB_WB-1:0]    i_wb_ctl,
    input  logic                i_debug,
    input  logic                i_step,
    input  logic [NB_DEPTH-1:0] i_addr_debug,
    input  logic                i_addr_sel,
    output logic [NB_BITS-1:0]  o_mem_data,
    output logic [NB_BITS-1:0]  o_alu_data,
    output logic [NB_REG-1:0]   o_reg_dst,
    output logic [NB_WB-1:0]    o_wb_ctl,
    output logic [NB_BITS-1:0]  o_data_debug,
    output logic                o_misalign
);
    logic                step_prev;
    logic                adv;
    logic [NB_DEPTH-1:0] idx;
    logic [1:0]          off;
    logic                mis;
    logic [3:0]          be;
    logic [NB_BITS-1:0]  wdata;
    logic [NB_BITS-1:0]  mem [2**NB_DEPTH];
    logic [NB_BITS-1:0]  rd_word;
    logic [1:0]          off_q;
    logic [1:0]          size_q;
    logic                uns_q;
    logic                mis_q;
    logic [7:0]          byte_v;
    logic [15:0]         half_v;

    assign adv = i_debug ? (i_step & ~step_prev) : 1'b1;
    assign idx = i_addr[NB_DEPTH+1:2];
    assign off = i_addr[1:0];
`ifdef MEM_MISALIGN_EXC_EN
    assign mis = ((i_size == 2'b01) & off[0]) | (i_size[1] & (off != 2'b00));
`else
    assign mis = 1'b0;
`endif
    assign be = (i_size == 2'b00) ? 4'b0001 << off :
                (i_size == 2'b01) ? 4'b0011 << {off[1], 1'b0} : 4'b1111;
    assign wdata = (i_size == 2'b00) ? {4{i_data[7:0]}} :
                   (i_size == 2'b01) ? {2{i_data[15:0]}} : i_data;

    // Memory is never reset; reset only blocks writes while asserted.
    always_ff @(posedge i_clk) begin
        if (!i_rst && adv && i_mem_wr && !mis)
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            step_prev    <= 1'b0;
            rd_word      <= '0;
            o_alu_data   <= '0;
            o_reg_dst    <= '0;
            o_wb_ctl     <= '0;
            off_q        <= '0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            mis_q        <= 1'b0;
            o_data_debug <= '0;
        end else begin
            step_prev <= i_step;
            if (adv && i_mem_rd) rd_word <= mis ? '0 : mem[idx];
            if (adv) begin
                o_alu_data <= i_addr;
                o_reg_dst  <= i_reg_dst;
                o_wb_ctl   <= i_wb_ctl;
                off_q      <= off;
                size_q     <= i_size;
                uns_q      <= i_unsigned;
                mis_q      <= mis & (i_mem_wr | i_mem_rd);
            end
            if (i_addr_sel) o_data_debug <= mem[i_addr_debug];
        end
    end

    assign byte_v     = rd_word[8*off_q +: 8];
    assign half_v     = rd_word[16*off_q[1] +: 16];
    assign o_mem_data = (size_q == 2'b00) ? {{(NB_BITS-8){byte_v[7] & ~uns_q}}, byte_v} :
                        (size_q == 2'b01) ? {{(NB_BITS-16){half_v[15] & ~uns_q}}, half_v} : rd_word;
    assign o_misalign = mis_q;
endmodule

// File: tb/tb_mem_stage_sized.sv
// tb_mem_stage_sized: directed bench for mem_stage_sized with a word-array reference model.
module tb_mem_stage_sized;
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [31:0] i_addr = '0;
    logic [31:0] i_data = '0;
    logic        i_mem_wr = 1'b0;
    logic        i_mem_rd = 1'b0;
    logic [1:0]  i_size = '0;
    logic        i_unsigned = 1'b0;
    logic [4:0]  i_reg_dst = '0;
    logic [1:0]  i_wb_ctl = '0;
    logic        i_debug = 1'b0;
    logic        i_step = 1'b0;
    logic [9:0]  i_addr_debug = '0;
    logic        i_addr_sel = 1'b0;
    logic [31:0] o_mem_data, o_alu_data, o_data_debug;
    logic [4:0]  o_reg_dst;
    logic [1:0]  o_wb_ctl;
    logic        o_misalign;

    mem_stage_sized dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_addr(i_addr), .i_data(i_data),
        .i_mem_wr(i_mem_wr), .i_mem_rd(i_mem_rd), .i_size(i_size), .i_unsigned(i_unsigned),
        .i_reg_dst(i_reg_dst), .i_wb_ctl(i_wb_ctl), .i_debug(i_debug), .i_step(i_step),
        .i_addr_debug(i_addr_debug), .i_addr_sel(i_addr_sel), .o_mem_data(o_mem_data),
        .o_alu_data(o_alu_data), .o_reg_dst(o_reg_dst), .o_wb_ctl(o_wb_ctl),
        .o_data_debug(o_data_debug), .o_misalign(o_misalign)
    );

    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_bad = 0;
    bit go = 1'b0;
    int seq = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: word-addressed memory plus the values each output must show.
    logic [31:0] m [1024];
    bit          mv [1024];
    logic [31:0] e_alu, e_word, e_dbg;
    logic [4:0]  e_rd;
    logic [1:0]  e_wb, e_off, e_sz;
    logic        e_un, e_mis, e_wv, e_dv, sp, a, ms;
    logic [9:0]  ix;
    logic [1:0]  of;
    int          sh;

    function automatic logic misf(input logic [1:0] sz, input logic [1:0] o);
`ifdef MEM_MISALIGN_EXC_EN
        return (sz == 2'd1 && o[0]) || (sz[1] && o != 2'd0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] o,
                                            input logic [1:0] sz, input logic un);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (w >> (8 * o)) & 32'hFF;
            if (!un && v[7]) v = v | 32'hFFFFFF00;
        end else if (sz == 2'd1) begin
            v = (w >> (o[1] ? 16 : 0)) & 32'hFFFF;
            if (!un && v[15]) v = v | 32'hFFFF0000;
        end else v = w;
        return v;
    endfunction

    always @(posedge i_clk) begin
        if (i_rst) begin
            e_alu = 0; e_rd = 0; e_wb = 0; e_off = 0; e_sz = 0; e_un = 0; e_mis = 0;
            e_word = 0; e_wv = 1; e_dbg = 0; e_dv = 1; sp = 0;
        end else begin
            a  = i_debug ? (i_step && !sp) : 1'b1;
            ix = i_addr[11:2];
            of = i_addr[1:0];
            ms = misf(i_size, of);
            if (i_addr_sel) begin e_dbg = m[i_addr_debug]; e_dv = mv[i_addr_debug]; end
            if (a && i_mem_rd) begin e_word = ms ? 32'h0 : m[ix]; e_wv = ms ? 1'b1 : mv[ix]; end
            if (a && i_mem_wr && !ms) begin
                if (i_size == 2'd0) begin
                    sh = 8 * of;
                    m[ix] = (m[ix] & ~(32'hFF << sh)) | ((i_data & 32'hFF) << sh);
                end else if (i_size == 2'd1) begin
                    sh = of[1] ? 16 : 0;
                    m[ix] = (m[ix] & ~(32'hFFFF << sh)) | ((i_data & 32'hFFFF) << sh);
                end else begin
                    m[ix] = i_data; mv[ix] = 1'b1;
                end
            end
            if (a) begin
                e_alu = i_addr; e_rd = i_reg_dst; e_wb = i_wb_ctl;
                e_off = of; e_sz = i_size; e_un = i_unsigned; e_mis = ms && (i_mem_wr || i_mem_rd);
            end
            sp = i_step;
        end
    end

    always @(negedge i_clk) begin
        if (go) begin
            chk("alu_data", o_alu_data, e_alu);
            chk("reg_dst", {27'd0, o_reg_dst}, {27'd0, e_rd});
            chk("wb_ctl", {30'd0, o_wb_ctl}, {30'd0, e_wb});
            chk("misalign", {31'd0, o_misalign}, {31'd0, e_mis});
            if (e_wv) chk("mem_data", o_mem_data, extract(e_word, e_off, e_sz, e_un));
            if (e_dv) chk("data_debug", o_data_debug, e_dbg);
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic op(input logic wr, input logic rd, input logic [1:0] sz, input logic un,
                      input logic [31:0] ad, input logic [31:0] d);
        tick();
        seq++;
        i_mem_wr = wr; i_mem_rd = rd; i_size = sz; i_unsigned = un;
        i_addr = ad; i_data = d; i_reg_dst = seq[4:0]; i_wb_ctl = seq[1:0];
    endtask

    logic [4:0] saved_rd;

    initial begin
        repeat (2) tick();
        go = 1'b1;
        chk("reset_alu", o_alu_data, 32'h0);
        chk("reset_mem", o_mem_data, 32'h0);
        i_rst = 1'b0;
        op(1, 0, 2, 0, 32'h10, 32'h12345678);
        op(1, 0, 2, 0, 32'h24, 32'h99999999);
        op(0, 1, 2, 0, 32'h10, 0);
        op(0, 1, 0, 0, 32'h11, 0);     chk("lw_0x10", o_mem_data, 32'h12345678);
                                       chk("lw_alu", o_alu_data, 32'h10);
        op(0, 1, 0, 0, 32'h13, 0);     chk("lb_0x11", o_mem_data, 32'h00000056);
        op(1, 0, 0, 0, 32'h12, 32'h80); chk("lb_0x13", o_mem_data, 32'h00000012);
        op(0, 1, 0, 0, 32'h12, 0);
        op(0, 1, 0, 1, 32'h12, 0);     chk("lb_0x12", o_mem_data, 32'hFFFFFF80);
        op(1, 0, 1, 0, 32'h10, 32'hBEEF); chk("lbu_0x12", o_mem_data, 32'h00000080);
        op(0, 1, 2, 0, 32'h10, 0);
        op(0, 1, 1, 0, 32'h10, 0);     chk("lw_after_sh", o_mem_data, 32'h1280BEEF);
        op(0, 1, 1, 1, 32'h10, 0);     chk("lh_0x10", o_mem_data, 32'hFFFFBEEF);
        op(0, 1, 1, 0, 32'h12, 0);     chk("lhu_0x10", o_mem_data, 32'h0000BEEF);
        op(0, 1, 3, 0, 32'h10, 0);     chk("lh_0x12", o_mem_data, 32'h00001280);
        op(0, 0, 0, 0, 32'h0, 0);      chk("lw_size3", o_mem_data, 32'h1280BEEF);
        // Step mode: step held high for five cycles must advance exactly once.
        op(0, 0, 0, 0, 32'h0, 0);
        i_debug = 1'b1; i_step = 1'b0;
        op(1, 0, 2, 0, 32'h20, 32'hAAAA5555);
        i_step = 1'b1; saved_rd = i_reg_dst;
        repeat (4) op(1, 0, 2, 0, 32'h24, 32'h11111111);
        op(0, 0, 0, 0, 32'h0, 0);
        i_step = 1'b0;
        chk("step_alu", o_alu_data, 32'h20);
        chk("step_reg_dst", {27'd0, o_reg_dst}, {27'd0, saved_rd});
        i_addr_sel = 1'b1; i_addr_debug = 10'd8;
        tick();                        chk("dbg_w8", o_data_debug, 32'hAAAA5555);
        i_addr_debug = 10'd9;
        tick();                        chk("dbg_w9", o_data_debug, 32'h99999999);
        i_addr_debug = 10'd4;
        tick();                        chk("dbg_w4", o_data_debug, 32'h1280BEEF);
        // Mid-stream reset with step held high through release.
        i_rst = 1'b1; i_step = 1'b1; i_addr = 32'h44;
        tick();
        chk("rst_alu", o_alu_data, 32'h0);
        chk("rst_mem", o_mem_data, 32'h0);
        chk("rst_dbg", o_data_debug, 32'h0);
        chk("rst_reg_dst", {27'd0, o_reg_dst}, 32'h0);
        i_rst = 1'b0;
        tick();                        chk("rel_alu", o_alu_data, 32'h44);
                                       chk("rel_dbg_kept", o_data_debug, 32'h1280BEEF);
        i_addr = 32'h48;
        repeat (2) tick();             chk("rel_one_adv", o_alu_data, 32'h44);
        i_debug = 1'b0; i_step = 1'b0;
        op(1, 0, 2, 0, 32'h11, 32'hFFFFFFFF);
        op(0, 0, 0, 0, 32'h0, 0);
`ifdef MEM_MISALIGN_EXC_EN
        chk("mis_flag", {31'd0, o_misalign}, 32'd1);
`else
        chk("mis_flag", {31'd0, o_misalign}, 32'd0);
`endif
        op(0, 0, 0, 0, 32'h0, 0);
        chk("mis_clear", {31'd0, o_misalign}, 32'd0);
`ifdef MEM_MISALIGN_EXC_EN
        chk("mis_word", o_data_debug, 32'h1280BEEF);
`else
        chk("mis_word", o_data_debug, 32'hFFFFFFFF);
`endif
        op(0, 1, 2, 0, 32'h10, 0);
        repeat (3) op(0, 0, 0, 0, 32'h0, 0);
        go = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
